multi_stepper_ctrl: RTL and testbench
=====================================

MULTI_STEPPER_CTRL -- requirements
Module: multi_stepper_ctrl

Interface
REQ-001 Parameter NUM_CH, default 2, is the number of independent stepper channels (1..8).
REQ-002 Parameter COUNT_W, default 16, is the width of the pulse-count field.
REQ-003 Parameter WIDTH_W, default 16, is the width of the half-period field, in clk_en ticks.
REQ-004 clk  input  1  system clock; single clock domain, all state on posedge clk.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 clk_en  input  1  module tick; all timing advances only on cycles with clk_en=1.
REQ-007 trigger  input  NUM_CH  per-channel start request, sampled on clk_en cycles.
REQ-008 abort  input  NUM_CH  per-channel stop request, sampled on clk_en cycles.
REQ-009 pulse_num  input  NUM_CH*COUNT_W  per-channel number of step pulses.
REQ-010 pulse_width  input  NUM_CH*WIDTH_W  per-channel half-period (high time = low time).
REQ-011 dir_in  input  NUM_CH  per-channel direction request.
REQ-012 step  output  NUM_CH  step pulse to driver.
REQ-013 dir  output  NUM_CH  latched direction, stable for the whole move.
REQ-014 busy  output  NUM_CH  channel is executing a move.
REQ-015 done  output  NUM_CH  one-clk-cycle pulse at move completion or abort.

Function
REQ-016 Each channel SHALL run its own FSM with states IDLE, HIGH, LOW; channels are fully independent.
REQ-017 In IDLE with clk_en=1 and trigger=1, the channel SHALL latch pulse_num, pulse_width and dir_in, and then go to HIGH on the next clk edge.
REQ-018 If the latched pulse_num=0 or pulse_width=0, the channel SHALL stay in IDLE, emit no step, and assert done on the following cycle.
REQ-019 In HIGH, step SHALL be 1 for exactly pulse_width clk_en ticks; the channel then goes to LOW.
REQ-020 In LOW, step SHALL be 0 for exactly pulse_width ticks; the channel then increments the pulse counter.
REQ-021 At the end of LOW, if the counter equals pulse_num the channel SHALL go to IDLE and pulse done; otherwise it SHALL return to HIGH.
REQ-022 busy SHALL be 1 in HIGH and LOW, and 0 in IDLE.
REQ-023 trigger while busy SHALL be ignored; latched values SHALL NOT change mid-move.
REQ-024 abort with clk_en=1 in HIGH or LOW SHALL force IDLE on the next edge, drive step to 0 immediately on that edge, and pulse done once.
REQ-025 abort in IDLE SHALL have no effect; abort and trigger together in IDLE SHALL let abort win (no move, no done).
REQ-026 Counters SHALL saturate at the latched targets and never wrap; the maximum pulse_num (2^COUNT_W-1) SHALL be executed fully.
REQ-027 When clk_en=0 the FSM, counters and step SHALL hold; done SHALL still be exactly one clk cycle wide.
REQ-028 dir SHALL update only at trigger acceptance, and at least one clk cycle before the first step rising edge.
REQ-029 Move length SHALL be 2*pulse_width*pulse_num clk_en ticks from entry to HIGH until return to IDLE.

Reset
REQ-030 While reset=1, all channels SHALL be in IDLE, with step=0, dir=0, busy=0, done=0, and counters and latched fields at 0.
REQ-031 Reset asserted mid-move SHALL abandon the move without a done pulse.
REQ-032 After reset deasserts, the first accepted trigger SHALL behave identically to any later one.

Structure
REQ-033 The shared package SHALL hold the channel state enum (IDLE/HIGH/LOW) and the default NUM_CH, COUNT_W and WIDTH_W constants.
REQ-034 The per-channel FSM with its counters SHALL be a sub-module stepper_channel, instantiated NUM_CH times by generate.
REQ-035 The top level SHALL contain only bus slicing and instantiation, with no cross-channel logic.

Verification
REQ-036 NUM_CH=2, clk_en=1, ch0 trigger with pulse_num=3 and pulse_width=2 -> exactly 3 step pulses, each high 2 cycles and low 2 cycles; busy high 12 cycles; one done; ch1 idle throughout.
REQ-037 pulse_num=0 (and separately pulse_width=0) -> no step, busy stays 0, done asserted exactly once.
REQ-038 Move pulse_num=5, pulse_width=1 with abort after the 2nd rising edge -> step=0 the next cycle, 2 pulses total, one done, busy falls.
REQ-039 clk_en asserted every 4th cycle, pulse_num=2, pulse_width=1 -> step high 4 clk cycles per phase; done is 1 cycle wide.
REQ-040 Re-trigger with new pulse_num=9 during a move of 4 -> 4 pulses only; dir unchanged until the next accepted trigger.
REQ-041 Asynchronous reset mid-HIGH -> step, busy and done drop to 0 without waiting for a clk edge; no done after release.

Source files
------------

// File: rtl/multi_stepper_ctrl_pkg.sv
// Shared types and default sizing for the multi-channel stepper controller.
package multi_stepper_ctrl_pkg;
  localparam int DEF_NUM_CH  = 2;
  localparam int DEF_COUNT_W = 16;
  localparam int DEF_WIDTH_W = 16;

  typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW} ch_state_e;
endpackage

// File: rtl/multi_stepper_ctrl_if.sv
// Command/status bundle between a motion sequencer (master) and the stepper controller (slave).
interface multi_stepper_ctrl_if
  import multi_stepper_ctrl_pkg::*;
#(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int COUNT_W = DEF_COUNT_W,
  parameter int WIDTH_W = DEF_WIDTH_W
);
  logic [NUM_CH-1:0]              trigger;
  logic [NUM_CH-1:0]              abort;
  logic [NUM_CH-1:0][COUNT_W-1:0] pulse_num;
  logic [NUM_CH-1:0][WIDTH_W-1:0] pulse_width;
  logic [NUM_CH-1:0]              dir_in;
  logic [NUM_CH-1:0]              step;
  logic [NUM_CH-1:0]              dir;
  logic [NUM_CH-1:0]              busy;
  logic [NUM_CH-1:0]              done;

  modport master (output trigger, abort, pulse_num, pulse_width, dir_in,
                  input  step, dir, busy, done);
  modport slave  (input  trigger, abort, pulse_num, pulse_width, dir_in,
                  output step, dir, busy, done);
endinterface

// File: rtl/multi_stepper_ctrl_stepper_channel.sv
// One stepper channel: latches a move on trigger, then emits pulse_num square pulses
// of pulse_width ticks high and low each; abort ends the move early.
module stepper_channel
  import multi_stepper_ctrl_pkg::*;
#(
  parameter int COUNT_W = DEF_COUNT_W,
  parameter int WIDTH_W = DEF_WIDTH_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_en,
  input  logic               trigger,
  input  logic               abort,
  input  logic [COUNT_W-1:0] pulse_num,
  input  logic [WIDTH_W-1:0] pulse_width,
  input  logic               dir_in,
  output logic               step,
  output logic               dir,
  output logic               busy,
  output logic               done
);
  ch_state_e          state;
  logic               start_pend;
  logic [COUNT_W-1:0] num_q, pcnt, pc_nxt;
  logic [WIDTH_W-1:0] wid_q, phcnt, ph_nxt;
  logic               ph_end;

  // Counters stop at target-1 before the compare, so the increment never wraps.
  assign ph_nxt = phcnt + WIDTH_W'(1);
  assign pc_nxt = pcnt + COUNT_W'(1);
  assign ph_end = (ph_nxt == wid_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      start_pend <= 1'b0;
      num_q      <= '0;
      wid_q      <= '0;
      pcnt       <= '0;
      phcnt      <= '0;
      step       <= 1'b0;
      dir        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clk_en) begin
        case (state)
          ST_IDLE: begin
            // One tick of IDLE after acceptance gives dir a full cycle of setup before step.
            if (start_pend) begin
              start_pend <= 1'b0;
              state      <= ST_HIGH;
              step       <= 1'b1;
              busy       <= 1'b1;
              phcnt      <= '0;
              pcnt       <= '0;
            end else if (trigger && !abort) begin
              num_q <= pulse_num;
              wid_q <= pulse_width;
              dir   <= dir_in;
              if (pulse_num == '0 || pulse_width == '0) done <= 1'b1;
              else                                      start_pend <= 1'b1;
            end
          end
          ST_HIGH: begin
            if (abort) begin
              state <= ST_IDLE;
              step  <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (ph_end) begin
              state <= ST_LOW;
              step  <= 1'b0;
              phcnt <= '0;
            end else begin
              phcnt <= ph_nxt;
            end
          end
          ST_LOW: begin
            if (abort) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (ph_end) begin
              phcnt <= '0;
              pcnt  <= pc_nxt;
              if (pc_nxt == num_q) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state <= ST_HIGH;
                step  <= 1'b1;
              end
            end else begin
              phcnt <= ph_nxt;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule

// File: rtl/multi_stepper_ctrl.sv
// Array of independent stepper channels; only slices the bus per channel.
module multi_stepper_ctrl
  import multi_stepper_ctrl_pkg::*;
#(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int COUNT_W = DEF_COUNT_W,
  parameter int WIDTH_W = DEF_WIDTH_W
) (
  input logic                  clk,
  input logic                  reset,
  input logic                  clk_en,
  multi_stepper_ctrl_if.slave  bus
);
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    stepper_channel #(.COUNT_W(COUNT_W), .WIDTH_W(WIDTH_W)) u_ch (
      .clk        (clk),
      .reset      (reset),
      .clk_en     (clk_en),
      .trigger    (bus.trigger[c]),
      .abort      (bus.abort[c]),
      .pulse_num  (bus.pulse_num[c]),
      .pulse_width(bus.pulse_width[c]),
      .dir_in     (bus.dir_in[c]),
      .step       (bus.step[c]),
      .dir        (bus.dir[c]),
      .busy       (bus.busy[c]),
      .done       (bus.done[c])
    );
  end
endmodule

// File: tb/tb_multi_stepper_ctrl.sv
// Directed scenarios plus randomized traffic checked against a tick-arithmetic model.
module tb_multi_stepper_ctrl;
  localparam int NC = 2;
  localparam int CW = 4;
  localparam int WW = 8;

  logic clk = 1'b0;
  logic rst;
  logic clk_en;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  multi_stepper_ctrl_if #(.NUM_CH(NC), .COUNT_W(CW), .WIDTH_W(WW)) ifc ();
  multi_stepper_ctrl #(.NUM_CH(NC), .COUNT_W(CW), .WIDTH_W(WW)) dut (
    .clk(clk), .reset(rst), .clk_en(clk_en), .bus(ifc)
  );

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    ifc.trigger = '0; ifc.abort = '0; ifc.pulse_num = '0; ifc.pulse_width = '0; ifc.dir_in = '0;
  endtask

  task automatic fire(input int ch, input int n, input int w, input bit d);
    ifc.pulse_num[ch] = CW'(n); ifc.pulse_width[ch] = WW'(w); ifc.dir_in[ch] = d; ifc.trigger[ch] = 1'b1;
  endtask

  // Runs ncyc cycles (dropping trigger after the first) and tallies activity on ch.
  task automatic measure(input int ch, input int ncyc, output int rises, output int hi_cyc,
                         output int busy_cyc, output int dones, output int hi_min,
                         output int hi_max, output int other);
    bit prev;
    int run;
    rises = 0; hi_cyc = 0; busy_cyc = 0; dones = 0; hi_min = 1000; hi_max = 0; other = 0;
    prev = ifc.step[ch]; run = 0;
    for (int i = 0; i < ncyc; i++) begin
      cyc();
      if (i == 0) ifc.trigger = '0;
      if (ifc.step[ch]) begin
        hi_cyc++; run++;
        if (!prev) rises++;
      end else if (run > 0) begin
        if (run < hi_min) hi_min = run;
        if (run > hi_max) hi_max = run;
        run = 0;
      end
      prev = ifc.step[ch];
      busy_cyc += int'(ifc.busy[ch]);
      dones    += int'(ifc.done[ch]);
      other    += int'(ifc.step[1-ch] | ifc.busy[1-ch] | ifc.done[1-ch]);
    end
    if (run > 0) begin
      if (run < hi_min) hi_min = run;
      if (run > hi_max) hi_max = run;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; clk_en = 1'b1; idle_inputs();
    repeat (3) cyc();
    tests++; if (ifc.step !== '0) begin fails++; $display("FAIL reset_step: got %b expected 0", ifc.step); end
    tests++; if (ifc.busy !== '0) begin fails++; $display("FAIL reset_busy: got %b expected 0", ifc.busy); end
    tests++; if (ifc.done !== '0) begin fails++; $display("FAIL reset_done: got %b expected 0", ifc.done); end
    tests++; if (ifc.dir  !== '0) begin fails++; $display("FAIL reset_dir: got %b expected 0", ifc.dir); end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_basic();
    int r, h, b, d, mn, mx, o;
    fire(0, 3, 2, 1'b1);
    cyc();
    ifc.trigger = '0;
    tests++; if (ifc.dir[0] !== 1'b1) begin fails++; $display("FAIL basic_dir_early: got %b expected 1", ifc.dir[0]); end
    tests++; if (ifc.step[0] !== 1'b0) begin fails++; $display("FAIL basic_step_after_dir: got %b expected 0", ifc.step[0]); end
    measure(0, 20, r, h, b, d, mn, mx, o);
    tests++; if (r != 3)  begin fails++; $display("FAIL basic_rises: got %0d expected 3", r); end
    tests++; if (h != 6)  begin fails++; $display("FAIL basic_high_cycles: got %0d expected 6", h); end
    tests++; if (b != 12) begin fails++; $display("FAIL basic_busy: got %0d expected 12", b); end
    tests++; if (d != 1)  begin fails++; $display("FAIL basic_done: got %0d expected 1", d); end
    tests++; if (mn != 2 || mx != 2) begin fails++; $display("FAIL basic_high_len: got %0d..%0d expected 2..2", mn, mx); end
    tests++; if (o != 0)  begin fails++; $display("FAIL basic_ch1_activity: got %0d expected 0", o); end
  endtask

  task automatic test_zero();
    int r, h, b, d, mn, mx, o;
    fire(0, 0, 3, 1'b0);
    measure(0, 8, r, h, b, d, mn, mx, o);
    tests++; if (r != 0 || b != 0) begin fails++; $display("FAIL zero_num_activity: got rises %0d busy %0d expected 0 0", r, b); end
    tests++; if (d != 1) begin fails++; $display("FAIL zero_num_done: got %0d expected 1", d); end
    fire(0, 4, 0, 1'b1);
    measure(0, 8, r, h, b, d, mn, mx, o);
    tests++; if (r != 0 || b != 0) begin fails++; $display("FAIL zero_width_activity: got rises %0d busy %0d expected 0 0", r, b); end
    tests++; if (d != 1) begin fails++; $display("FAIL zero_width_done: got %0d expected 1", d); end
  endtask

  task automatic test_abort();
    int r, h, b, d, mn, mx, o, k;
    bit prev;
    fire(0, 5, 1, 1'b0);
    r = 0; k = 0; prev = 1'b0;
    while (r < 2 && k < 20) begin
      cyc();
      if (k == 0) ifc.trigger = '0;
      if (ifc.step[0] && !prev) r++;
      prev = ifc.step[0]; k++;
    end
    tests++; if (r != 2) begin fails++; $display("FAIL abort_wait_second_rise: got %0d rises expected 2", r); end
    ifc.abort[0] = 1'b1;
    cyc();
    ifc.abort[0] = 1'b0;
    tests++; if (ifc.step[0] !== 1'b0) begin fails++; $display("FAIL abort_step: got %b expected 0", ifc.step[0]); end
    tests++; if (ifc.busy[0] !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b expected 0", ifc.busy[0]); end
    tests++; if (ifc.done[0] !== 1'b1) begin fails++; $display("FAIL abort_done: got %b expected 1", ifc.done[0]); end
    measure(0, 12, r, h, b, d, mn, mx, o);
    tests++; if (r != 0 || d != 0 || b != 0) begin fails++; $display("FAIL abort_after: got rises %0d done %0d busy %0d expected 0 0 0", r, d, b); end
  endtask

  task automatic test_clk_en();
    int r, b, d, dmax, drun, run, mn, mx;
    bit prev;
    r = 0; b = 0; d = 0; dmax = 0; drun = 0; run = 0; mn = 1000; mx = 0; prev = 1'b0;
    for (int i = 0; i < 60; i++) begin
      clk_en = (i % 4 == 0);
      if (i == 0) fire(0, 2, 1, 1'b1);
      cyc();
      if (i == 0) ifc.trigger = '0;
      if (ifc.step[0]) begin run++; if (!prev) r++; end
      else if (run > 0) begin
        if (run < mn) mn = run;
        if (run > mx) mx = run;
        run = 0;
      end
      prev = ifc.step[0];
      b += int'(ifc.busy[0]);
      if (ifc.done[0]) begin d++; drun++; if (drun > dmax) dmax = drun; end else drun = 0;
    end
    clk_en = 1'b1;
    tests++; if (r != 2) begin fails++; $display("FAIL clken_rises: got %0d expected 2", r); end
    tests++; if (mn != 4 || mx != 4) begin fails++; $display("FAIL clken_high_len: got %0d..%0d expected 4..4", mn, mx); end
    tests++; if (b != 16) begin fails++; $display("FAIL clken_busy: got %0d expected 16", b); end
    tests++; if (d != 1 || dmax != 1) begin fails++; $display("FAIL clken_done_width: got %0d cycles run %0d expected 1 1", d, dmax); end
  endtask

  task automatic test_retrigger();
    int r, d, dir_bad, h, b, mn, mx, o;
    bit prev;
    r = 0; d = 0; dir_bad = 0; prev = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i == 0) fire(0, 4, 1, 1'b1);
      if (i == 4) begin ifc.pulse_num[0] = CW'(9); ifc.dir_in[0] = 1'b0; ifc.trigger[0] = 1'b1; end
      cyc();
      ifc.trigger[0] = 1'b0;
      if (ifc.step[0] && !prev) r++;
      prev = ifc.step[0];
      d += int'(ifc.done[0]);
      if (ifc.dir[0] !== 1'b1) dir_bad++;
    end
    tests++; if (r != 4) begin fails++; $display("FAIL retrig_rises: got %0d expected 4", r); end
    tests++; if (d != 1) begin fails++; $display("FAIL retrig_done: got %0d expected 1", d); end
    tests++; if (dir_bad != 0) begin fails++; $display("FAIL retrig_dir_changed: got %0d bad cycles expected 0", dir_bad); end
    fire(0, 1, 1, 1'b0);
    cyc();
    ifc.trigger = '0;
    tests++; if (ifc.dir[0] !== 1'b0) begin fails++; $display("FAIL retrig_dir_next: got %b expected 0", ifc.dir[0]); end
    measure(0, 6, r, h, b, d, mn, mx, o);
    tests++; if (r != 1 || d != 1) begin fails++; $display("FAIL retrig_next_move: got rises %0d done %0d expected 1 1", r, d); end
  endtask

  task automatic test_max();
    int r, h, b, d, mn, mx, o;
    fire(1, 15, 1, 1'b1);
    measure(1, 40, r, h, b, d, mn, mx, o);
    tests++; if (r != 15) begin fails++; $display("FAIL max_rises: got %0d expected 15", r); end
    tests++; if (b != 30) begin fails++; $display("FAIL max_busy: got %0d expected 30", b); end
    tests++; if (d != 1)  begin fails++; $display("FAIL max_done: got %0d expected 1", d); end
    tests++; if (o != 0)  begin fails++; $display("FAIL max_ch0_activity: got %0d expected 0", o); end
  endtask

  task automatic test_async_reset();
    int r, h, b, d, mn, mx, o;
    fire(0, 5, 3, 1'b1);
    cyc();
    ifc.trigger = '0;
    cyc();
    tests++; if (ifc.step[0] !== 1'b1 || ifc.busy[0] !== 1'b1) begin fails++; $display("FAIL areset_pre: got step %b busy %b expected 1 1", ifc.step[0], ifc.busy[0]); end
    #2 rst = 1'b1;
    #1;
    tests++; if ({ifc.step[0], ifc.busy[0], ifc.done[0], ifc.dir[0]} !== 4'b0000) begin
      fails++; $display("FAIL areset_async: got step/busy/done/dir %b expected 0000", {ifc.step[0], ifc.busy[0], ifc.done[0], ifc.dir[0]});
    end
    rst = 1'b0;
    measure(0, 30, r, h, b, d, mn, mx, o);
    tests++; if (r != 0 || d != 0 || b != 0) begin fails++; $display("FAIL areset_after: got rises %0d done %0d busy %0d expected 0 0 0", r, d, b); end
  endtask

  // Model: a move is a span of 2*w*n ticks; step is high on even w-tick slots.
  task automatic test_random();
    bit mv[NC], pend[NC], ed[NC], edn[NC], eb, es;
    int t[NC], mn[NC], mw[NC];
    bit en;
    bit [NC-1:0] trg, abt, din;
    int num[NC], wid[NC];
    logic [3:0] exp_v, got_v;
    rst = 1'b1; idle_inputs(); clk_en = 1'b1;
    cyc();
    rst = 1'b0;
    for (int c = 0; c < NC; c++) begin mv[c] = 0; pend[c] = 0; ed[c] = 0; t[c] = 0; mn[c] = 0; mw[c] = 0; end
    for (int k = 0; k < 2000; k++) begin
      en = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < NC; c++) begin
        trg[c] = ($urandom_range(0, 5) == 0);
        abt[c] = ($urandom_range(0, 24) == 0);
        din[c] = 1'($urandom_range(0, 1));
        num[c] = $urandom_range(0, 5);
        wid[c] = $urandom_range(0, 3);
        ifc.pulse_num[c] = CW'(num[c]); ifc.pulse_width[c] = WW'(wid[c]);
      end
      clk_en = en; ifc.trigger = trg; ifc.abort = abt; ifc.dir_in = din;
      cyc();
      for (int c = 0; c < NC; c++) begin
        edn[c] = 1'b0;
        if (!mv[c]) begin
          if (en && trg[c] && !abt[c]) begin
            mn[c] = num[c]; mw[c] = wid[c]; ed[c] = din[c];
            if (num[c] == 0 || wid[c] == 0) edn[c] = 1'b1;
            else begin mv[c] = 1'b1; pend[c] = 1'b1; end
          end
        end else if (pend[c]) begin
          if (en) begin pend[c] = 1'b0; t[c] = 0; end
        end else if (en) begin
          if (abt[c]) begin mv[c] = 1'b0; edn[c] = 1'b1; end
          else begin
            t[c]++;
            if (t[c] == 2 * mw[c] * mn[c]) begin mv[c] = 1'b0; edn[c] = 1'b1; end
          end
        end
        eb = mv[c] && !pend[c];
        es = eb && ((t[c] / mw[c]) % 2 == 0);
        exp_v = {es, eb, edn[c], ed[c]};
        got_v = {ifc.step[c], ifc.busy[c], ifc.done[c], ifc.dir[c]};
        tests++;
        if (got_v !== exp_v) begin
          fails++;
          $display("FAIL random_ch%0d cycle %0d: got step/busy/done/dir %b expected %b", c, k, got_v, exp_v);
        end
      end
    end
    idle_inputs(); clk_en = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; clk_en = 1'b1; idle_inputs();
    test_reset();
    test_basic();
    test_zero();
    test_abort();
    test_clk_en();
    test_retrigger();
    test_max();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
